// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS decode stage: load-use stalls,
// taken-branch flushes and mult/div busy interlock. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int MD_LATENCY = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [ADDR_WIDTH-1:0] regS_addr_id,
  input  logic [ADDR_WIDTH-1:0] regT_addr_id,
  input  logic                  uses_rt_id,
  input  logic                  ex_mem_rd,
  input  logic [ADDR_WIDTH-1:0] ex_wr_addr,
  input  logic                  branch_taken,
  input  logic                  md_start_id,
  input  logic                  md_read_id,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  if_flush,
  output logic                  idex_bubble,
  output logic                  md_busy,
  output logic                  md_issue
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  typedef enum logic {RUN, MD_BUSY} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_RELOAD = CNT_WIDTH'(MD_LATENCY - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] md_cnt_q, md_cnt_d;

  logic lu_hit;
  logic md_stall;
  logic busy_int;

  assign busy_int = (state_q == MD_BUSY);

  assign lu_hit = ex_mem_rd && (ex_wr_addr != '0) &&
                  ((ex_wr_addr == regS_addr_id) ||
                   (uses_rt_id && (ex_wr_addr == regT_addr_id)));

  assign md_stall = busy_int && (md_start_id || md_read_id) && (md_cnt_q != '0);

  // Outputs are forced low while rstb is asserted, even though inputs may still toggle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    if_flush    = 1'b0;
    idex_bubble = 1'b0;
    md_issue    = 1'b0;
    md_busy     = 1'b0;
    if (rstb) begin
      md_busy = busy_int;
      if (branch_taken) begin
        if_flush    = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu_hit || md_stall) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end else begin
        md_issue = md_start_id;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      RUN: begin
        if (md_issue) begin
          state_d  = MD_BUSY;
          md_cnt_d = CNT_RELOAD;
        end
      end
      MD_BUSY: begin
        // A taken branch does not cancel the unit: the count runs regardless.
        if (md_cnt_q != '0) begin
          md_cnt_d = md_cnt_q - 1'b1;
        end else if (md_issue) begin
          md_cnt_d = CNT_RELOAD;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (pc_hold)  stall_cycles_q <= stall_cycles_q + 32'd1;
      if (if_flush) flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MD_LATENCY=4.
// Output vector order: {pc_hold, ifid_hold, if_flush, idex_bubble, md_busy, md_issue}.
module tb_hazard_ctrl;

  localparam int AW = 5;

  logic          clk;
  logic          rstb;
  logic [AW-1:0] regS_addr_id, regT_addr_id, ex_wr_addr;
  logic          uses_rt_id, ex_mem_rd, branch_taken, md_start_id, md_read_id;
  logic          pc_hold, ifid_hold, if_flush, idex_bubble, md_busy, md_issue;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_count;
`endif

  logic [5:0] outs;
  assign outs = {pc_hold, ifid_hold, if_flush, idex_bubble, md_busy, md_issue};

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.ADDR_WIDTH(AW), .MD_LATENCY(4), .CNT_WIDTH(3)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .regS_addr_id (regS_addr_id),
    .regT_addr_id (regT_addr_id),
    .uses_rt_id   (uses_rt_id),
    .ex_mem_rd    (ex_mem_rd),
    .ex_wr_addr   (ex_wr_addr),
    .branch_taken (branch_taken),
    .md_start_id  (md_start_id),
    .md_read_id   (md_read_id),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .if_flush     (if_flush),
    .idex_bubble  (idex_bubble),
    .md_busy      (md_busy),
    .md_issue     (md_issue)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    regS_addr_id = '0;
    regT_addr_id = '0;
    ex_wr_addr   = '0;
    uses_rt_id   = 1'b0;
    ex_mem_rd    = 1'b0;
    branch_taken = 1'b0;
    md_start_id  = 1'b0;
    md_read_id   = 1'b0;
  endtask

  // Advance to 1 ns after the next rising edge; inputs are then driven and sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    idle_inputs();
    ex_mem_rd = 1'b1; ex_wr_addr = 5'd8; regS_addr_id = 5'd8;
    branch_taken = 1'b1; md_start_id = 1'b1;
    #3;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL reset_outputs got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    next_cycle();
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL reset_hold got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    idle_inputs();
    #2 rstb = 1'b1;
    next_cycle();
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL reset_release_idle got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
  endtask

  task automatic test_load_use_rs();
    idle_inputs();
    ex_mem_rd = 1'b1; ex_wr_addr = 5'd8; regS_addr_id = 5'd8; regT_addr_id = 5'd3;
    #1;
    checks++;
    if (outs !== 6'b110100) begin
      $display("FAIL load_use_rs got=%b exp=%b", outs, 6'b110100);
      errors++;
    end
    next_cycle();
    ex_mem_rd = 1'b0; ex_wr_addr = 5'd0;
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL load_use_rs_release got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_rt_and_zero();
    idle_inputs();
    ex_mem_rd = 1'b1; ex_wr_addr = 5'd9; regT_addr_id = 5'd9; regS_addr_id = 5'd3;
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL rt_unused got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    next_cycle();
    uses_rt_id = 1'b1;
    #1;
    checks++;
    if (outs !== 6'b110100) begin
      $display("FAIL rt_used got=%b exp=%b", outs, 6'b110100);
      errors++;
    end
    next_cycle();
    uses_rt_id = 1'b1; ex_wr_addr = 5'd0; regS_addr_id = 5'd0; regT_addr_id = 5'd0;
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL load_to_zero got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_branch_priority();
    idle_inputs();
    ex_mem_rd = 1'b1; ex_wr_addr = 5'd8; regS_addr_id = 5'd8; branch_taken = 1'b1;
    #1;
    checks++;
    if (outs !== 6'b001100) begin
      $display("FAIL branch_over_lu got=%b exp=%b", outs, 6'b001100);
      errors++;
    end
    next_cycle();
    idle_inputs();
    branch_taken = 1'b1; md_start_id = 1'b1;
    #1;
    checks++;
    if (outs !== 6'b001100) begin
      $display("FAIL branch_blocks_issue got=%b exp=%b", outs, 6'b001100);
      errors++;
    end
    next_cycle();
    idle_inputs();
    md_read_id = 1'b1;
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL no_busy_after_branch got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_md_interlock();
    logic [5:0] exp_seq [5];
    exp_seq = '{6'b110110, 6'b110110, 6'b110110, 6'b000010, 6'b000000};
    idle_inputs();
    md_start_id = 1'b1;
    #1;
    checks++;
    if (outs !== 6'b000001) begin
      $display("FAIL md_issue got=%b exp=%b", outs, 6'b000001);
      errors++;
    end
    next_cycle();
    md_start_id = 1'b0; md_read_id = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) md_read_id = 1'b0;
      #1;
      checks++;
      if (outs !== exp_seq[i]) begin
        $display("FAIL md_interlock_t%0d got=%b exp=%b", i + 1, outs, exp_seq[i]);
        errors++;
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_seq [9];
    exp_seq = '{6'b000001, 6'b110110, 6'b110110, 6'b110110, 6'b000011,
                6'b110110, 6'b001110, 6'b110110, 6'b000010};
    idle_inputs();
    for (int i = 0; i < 9; i++) begin
      // t..t+4: second mult waits in ID; then an mfhi, with a taken branch at t+6.
      md_start_id  = (i <= 4);
      md_read_id   = (i >= 5);
      branch_taken = (i == 6);
      #1;
      checks++;
      if (outs !== exp_seq[i]) begin
        $display("FAIL back_to_back_t%0d got=%b exp=%b", i, outs, exp_seq[i]);
        errors++;
      end
      next_cycle();
    end
    idle_inputs();
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL back_to_back_done got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_non_md_during_busy();
    idle_inputs();
    md_start_id = 1'b1;
    next_cycle();
    md_start_id = 1'b0;
    #1;
    checks++;
    if (outs !== 6'b000010) begin
      $display("FAIL non_md_no_stall got=%b exp=%b", outs, 6'b000010);
      errors++;
    end
    repeat (4) next_cycle();
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL non_md_busy_end got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_busy();
    idle_inputs();
    md_start_id = 1'b1;
    next_cycle();
    md_start_id = 1'b0; md_read_id = 1'b1;
    next_cycle();
    // md_cnt is 2 here.
    #1;
    checks++;
    if (outs !== 6'b110110) begin
      $display("FAIL pre_reset_stall got=%b exp=%b", outs, 6'b110110);
      errors++;
    end
    rstb = 1'b0;
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL reset_mid_busy got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    #3 rstb = 1'b1;
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL mfhi_after_reset got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    next_cycle();
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      $display("FAIL mfhi_after_reset_next got=%b exp=%b", outs, 6'b000000);
      errors++;
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use_rs();
    test_rt_and_zero();
    test_branch_priority();
    test_md_interlock();
    test_back_to_back();
    test_non_md_during_busy();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
